mul8_seq_ctrl: RTL and testbench
================================

Name: mul8_seq_ctrl

Overview:
- Sequential 8x8 unsigned shift-and-add multiplier controller; produces a 16-bit product.
- Does not own an adder. It borrows the shared 8-bit ALU adder through a request/grant port, so the ALU sequencer can keep that adder for ordinary instructions and lend it for MUL.
- Sits beside the ALU. The CPU control unit starts it and waits for done.

Parameters:
- DONE_HOLD, 0, 0: done is a 1-cycle pulse. 1: done stays high until the next accepted start or reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  8  multiplicand, captured when start is accepted.
- b  input  8  multiplier, captured when start is accepted.
- busy  output  1  high while a multiply is in progress (RUN state).
- done  output  1  result valid strobe (see DONE_HOLD).
- product  output  16  registered result; holds its value until the next completion.
- hi_nz  output  1  product[15:8] != 0; registered with product (8-bit result overflow).
- add_req  output  1  request for the shared adder; high in RUN.
- add_gnt  input  1  adder granted this cycle.
- add_a  output  8  adder operand A.
- add_b  output  8  adder operand B.
- add_cin  output  1  adder carry-in; always 0.
- add_s  input  8  adder sum; combinational return in the same cycle.
- add_cout  input  1  adder carry-out; same cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - busy, done, add_req, hi_nz = 0.
  - product = 16'h0000.
  - internal acc, q, mcand = 0; cnt = 0.
  - Reset mid-multiply abandons the operation; no done is produced.
- Internal registers: acc[7:0], q[7:0], mcand[7:0], cnt[3:0].
- IDLE:
  - add_a, add_b, add_cin = 0; add_req = 0.
  - start=1 at a clock edge: mcand<=a, q<=b, acc<=0, cnt<=0, go to RUN.
- RUN:
  - busy=1, add_req=1.
  - add_a=acc; add_b = q[0] ? mcand : 8'h00; add_cin=0.
  - Iteration fires on an edge where add_gnt=1:
    - acc <= {add_cout, add_s[7:1]}
    - q <= {add_s[0], q[7:1]}
    - cnt <= cnt+1
  - add_gnt=0: all registers hold (stall); add_req stays high; add_a/add_b stay stable.
  - Iteration fired with cnt==7: go to DONE.
  - RUN exactly 8 granted cycles; ungranted cycles extend it.
- DONE (one cycle):
  - On entry edge: product <= {acc_next, q_next}, i.e. the values after the 8th iteration; hi_nz updated with product.
  - done=1 and busy=0 during this cycle.
  - Next state is IDLE unconditionally. start seen in the DONE cycle is ignored; the requester re-asserts it in IDLE.
- done behaviour:
  - DONE_HOLD=0: done is high only in the DONE-state cycle.
  - DONE_HOLD=1: done is set on DONE entry and cleared on the edge that accepts the next start.
- Latency with add_gnt tied high:
  - start sampled at edge k.
  - busy high for the 8 cycles after edges k..k+7.
  - product valid and done high after edge k+8.
  - 9 cycles from start to done.
- start while busy or DONE: ignored; a and b are not recaptured.
- Arithmetic:
  - Pure unsigned. Result = a*b mod 2^16, exact; max 255*255 = 16'hFE01.
  - Carry-out is kept in acc[7] every iteration; no bit loss.
- add_gnt is ignored outside RUN.
- Operands a and b need only be valid at the accepting edge.

Test Plan:
- Reset check: assert rst_n=0 mid-RUN (a=8'hFF, b=8'hFF, after 4 iterations) -> immediately busy=0, product=16'h0000, add_req=0; no done pulse after release.
- Basic multiply: add_gnt=1, a=8'h0C, b=8'h0A, start 1 cycle -> busy 8 cycles; done 9 cycles after start; product=16'h0078; hi_nz=0.
- Max operands: a=8'hFF, b=8'hFF -> product=16'hFE01, hi_nz=1.
- Zero and identity: a=8'h00, b=8'h9A -> 16'h0000. Then a=8'h01, b=8'h80 -> 16'h0080. Each still takes the full 8 iterations.
- Grant stalls: a=8'h35, b=8'h07; drop add_gnt for 3 random cycles during RUN -> done at 12 cycles after start; product=16'h0173; add_a/add_b stable during each stall.
- Ignored start and DONE_HOLD:
  - Pulse start with a=8'h02, b=8'h02 while busy on a 8'h10 x 8'h10 multiply -> product=16'h0100; no second operation.
  - With DONE_HOLD=1, done stays high until the next accepted start.

Source files
------------

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned shift-and-add multiplier that borrows the shared ALU
// adder through a request/grant handshake; one iteration per granted cycle.
module mul8_seq_ctrl #(
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        hi_nz,
  output logic        add_req,
  input  logic        add_gnt,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_cin,
  input  logic [7:0]  add_s,
  input  logic        add_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] acc, q, mcand;
  logic [3:0] cnt;
  logic       done_r;
  logic       fire;
  logic [7:0] acc_nxt, q_nxt;

  // Carry-out re-enters at the top of acc, so no partial-product bit is lost.
  assign acc_nxt = {add_cout, add_s[7:1]};
  assign q_nxt   = {add_s[0], q[7:1]};
  assign add_cin = 1'b0;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    add_req   = 1'b0;
    add_a     = 8'h00;
    add_b     = 8'h00;
    fire      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy    = 1'b1;
        add_req = 1'b1;
        add_a   = acc;
        add_b   = q[0] ? mcand : 8'h00;
        fire    = add_gnt;
        if (add_gnt && cnt == 4'd7) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= 8'h00;
      q       <= 8'h00;
      mcand   <= 8'h00;
      cnt     <= 4'd0;
      product <= 16'h0000;
      hi_nz   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        mcand  <= a;
        q      <= b;
        acc    <= 8'h00;
        cnt    <= 4'd0;
        done_r <= 1'b0;
      end
      if (fire) begin
        acc <= acc_nxt;
        q   <= q_nxt;
        cnt <= cnt + 4'd1;
        if (cnt == 4'd7) begin
          product <= {acc_nxt, q_nxt};
          hi_nz   <= |acc_nxt;
          done_r  <= 1'b1;
        end
      end
    end
  end

  // Held variant stays up until the edge that accepts the next start.
  assign done = DONE_HOLD ? done_r : (state == DONE);

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Randomized bench for mul8_seq_ctrl: a pulsed-done and a held-done instance run
// side by side, each with its own adder, checked against a*b and grant counting.
module tb_mul8_seq_ctrl;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, add_gnt = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;

  logic busy0, done0, hnz0, req0, cin0, co0;
  logic [15:0] prod0;
  logic [7:0] aa0, ab0, s0;
  logic busy1, done1, hnz1, req1, cin1, co1;
  logic [15:0] prod1;
  logic [7:0] aa1, ab1, s1;

  int checks = 0, failures = 0;
  bit held1 = 1'b0;
  logic [15:0] last_prod = 16'h0000;

  always #5 clk = ~clk;

  assign {co0, s0} = {1'b0, aa0} + {1'b0, ab0} + {8'h00, cin0};
  assign {co1, s1} = {1'b0, aa1} + {1'b0, ab1} + {8'h00, cin1};

  mul8_seq_ctrl #(.DONE_HOLD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .product(prod0), .hi_nz(hnz0),
    .add_req(req0), .add_gnt(add_gnt), .add_a(aa0), .add_b(ab0),
    .add_cin(cin0), .add_s(s0), .add_cout(co0));

  mul8_seq_ctrl #(.DONE_HOLD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .product(prod1), .hi_nz(hnz1),
    .add_req(req1), .add_gnt(add_gnt), .add_a(aa1), .add_b(ab1),
    .add_cin(cin1), .add_s(s1), .add_cout(co1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One multiply: nst stalls placed randomly in RUN; optional start poke while
  // busy (2x2) and optional start during the DONE cycle, both must be ignored.
  task automatic do_mul(input logic [7:0] ta, input logic [7:0] tb, input int nst,
                        input bit poke, input bit sid);
    logic [15:0] exp_p;
    int n, iters, ns_left;
    bit g, poked;
    logic [7:0] pa, pb;
    exp_p = 16'(ta) * 16'(tb);
    n = 0; iters = 0; ns_left = nst; poked = 1'b0;
    @(negedge clk);
    chk("idle_prod_hold", prod0, last_prod);
    chk("idle_hold_done", done1, held1);
    chk("idle_busy", busy0, 1'b0);
    a = ta; b = tb; start = 1'b1; add_gnt = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    chk("hold_done_clr", done1, 1'b0);
    while (done0 !== 1'b1 && n < 40) begin
      chk("run_busy", busy0, iters < 8);
      chk("run_req", req0, iters < 8);
      chk("run_cin", cin0, 1'b0);
      chk("run_done1", done1, 1'b0);
      g = 1'b1;
      if (ns_left > 0 && (ns_left >= 8 - iters || $urandom_range(0, 2) == 0)) begin
        g = 1'b0; ns_left--;
      end
      add_gnt = g;
      pa = aa0; pb = ab0;
      if (poke && !poked && iters == 3) begin
        start = 1'b1; a = 8'h02; b = 8'h02; poked = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (g) iters++;
      else begin
        chk("stall_add_a", aa0, pa);
        chk("stall_add_b", ab0, pb);
      end
    end
    add_gnt = 1'($urandom);
    chk("latency", n, 8 + nst);
    chk("done_pulse", done0, 1'b1);
    chk("done_hold", done1, 1'b1);
    chk("done_busy", busy0, 1'b0);
    chk("product", prod0, exp_p);
    chk("product_h", prod1, exp_p);
    chk("hi_nz", hnz0, exp_p[15:8] != 8'h00);
    last_prod = exp_p;
    held1 = 1'b1;
    if (sid) begin
      start = 1'b1; a = 8'h33; b = 8'h44;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_busy", busy0, 1'b0);
    chk("post_done", done0, 1'b0);
    chk("post_hold", done1, 1'b1);
    chk("post_prod", prod0, exp_p);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_prod", prod0, 16'h0000);
    chk("rst_hinz", hnz0, 1'b0);
    chk("rst_req", req0, 1'b0);
    chk("rst_adda", aa0, 8'h00);
    @(negedge clk); rst_n = 1'b1;

    do_mul(8'h0C, 8'h0A, 0, 1'b0, 1'b0);
    do_mul(8'hFF, 8'hFF, 0, 1'b0, 1'b0);
    do_mul(8'h00, 8'h9A, 0, 1'b0, 1'b0);
    do_mul(8'h01, 8'h80, 0, 1'b0, 1'b0);
    do_mul(8'h35, 8'h07, 3, 1'b0, 1'b0);
    do_mul(8'h10, 8'h10, 0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("idle_hold_long", done1, 1'b1);
    for (int i = 0; i < 16; i++)
      do_mul(8'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
             1'($urandom), 1'($urandom));

    // Reset in the middle of an FF x FF multiply abandons it.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1; add_gnt = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_prod", prod0, 16'h0000);
    chk("mid_rst_req", req0, 1'b0);
    chk("mid_rst_hold", done1, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", done0 | done1 | busy0, 1'b0);
    end
    held1 = 1'b0; last_prod = 16'h0000;
    do_mul(8'hFF, 8'hFF, 2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
